// File: rtl/ql_ram_arbiter.sv
// SDRAM port arbiter: 68008 CPU path (priority) vs word-wide DMA, windows aligned to sync.
// Define ARB_STATS_EN to add per-window grant counters (stat_cpu/stat_dma/stat_forced, stat_clr).
module ql_ram_arbiter #(
    parameter int unsigned SLOT_LEN   = 8,
    parameter int unsigned RD_LAT     = 6,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned AW         = 24
) (
    input  logic          clk_sys,
    input  logic          RESET,
    input  logic          sync,
    input  logic          cpu_oe,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_din,
    input  logic [1:0]    cpu_ds,
    output logic [15:0]   cpu_dout,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [15:0]   dma_din,
    input  logic [1:0]    dma_ds,
    output logic          dma_ack,
    output logic [15:0]   dma_dout,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_din,
    output logic          mem_we,
    output logic          mem_oe,
    output logic [1:0]    mem_ds,
    input  logic [15:0]   mem_dout,
    output logic          busy
`ifdef ARB_STATS_EN
    ,
    input  logic          stat_clr,
    output logic [15:0]   stat_cpu,
    output logic [15:0]   stat_dma,
    output logic [15:0]   stat_forced
`endif
);

    localparam int unsigned CW = $clog2(SLOT_LEN + 1);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve;
    logic          pend;
    logic          win_we;
    logic [15:0]   dma_dout_q;

    logic          cpu_req, in_flight, starved, forced;
    logic          grant_cpu, grant_dma, forced_win;
    logic [CW-1:0] tgt;
    logic          at_point, dma_rd_ack, cpu_cap;

    // pend marks a window whose completion point (ack/capture) has not yet been reached;
    // a sync before that point leaves it unserved and the DMA side re-requests next window.
    always_comb begin
        cpu_req    = cpu_oe | cpu_we;
        in_flight  = (state == DMA_ACC) && pend;
        starved    = (starve == SW'(STARVE_MAX));
        forced     = dma_req && starved && !in_flight;
        grant_cpu  = cpu_req && !forced;
        grant_dma  = !grant_cpu && dma_req && !in_flight;
        forced_win = grant_dma && starved;
        tgt        = win_we ? CW'(1) : CW'(RD_LAT);
        at_point   = pend && !sync && (cnt == tgt);
        dma_ack    = (state == DMA_ACC) && at_point && dma_req;
        dma_rd_ack = dma_ack && !win_we;
        cpu_cap    = (state == CPU_ACC) && at_point && !win_we;
        dma_dout   = dma_rd_ack ? mem_dout : dma_dout_q;
        busy       = (state == DMA_ACC);
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            starve     <= '0;
            pend       <= 1'b0;
            win_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_ds     <= '0;
            mem_we     <= 1'b0;
            mem_oe     <= 1'b0;
            cpu_dout   <= 16'hFFFF;
            dma_dout_q <= '0;
            cpu_stall  <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            mem_oe <= 1'b0;
            if (at_point)   pend       <= 1'b0;
            if (cpu_cap)    cpu_dout   <= mem_dout;
            if (dma_rd_ack) dma_dout_q <= mem_dout;

            if (sync)
                cnt <= CW'(1);
            else if (cnt == CW'(SLOT_LEN - 1))
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);

            if (sync) begin
                pend      <= grant_cpu | grant_dma;
                cpu_stall <= forced_win && cpu_req;
                if (grant_cpu) begin
                    state    <= CPU_ACC;
                    win_we   <= cpu_we;
                    mem_addr <= cpu_addr;
                    mem_din  <= cpu_din;
                    mem_ds   <= cpu_ds;
                    mem_we   <= cpu_we;
                    mem_oe   <= !cpu_we;
                    if (dma_req && !starved)
                        starve <= starve + SW'(1);
                end else if (grant_dma) begin
                    state    <= DMA_ACC;
                    win_we   <= dma_we;
                    mem_addr <= dma_addr;
                    mem_din  <= dma_din;
                    mem_ds   <= dma_ds;
                    mem_we   <= dma_we;
                    mem_oe   <= !dma_we;
                    starve   <= '0;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk_sys) begin
        if (RESET || stat_clr) begin
            stat_cpu    <= '0;
            stat_dma    <= '0;
            stat_forced <= '0;
        end else if (sync) begin
            if (grant_cpu)  stat_cpu    <= stat_cpu + 16'd1;
            if (grant_dma)  stat_dma    <= stat_dma + 16'd1;
            if (forced_win) stat_forced <= stat_forced + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ql_ram_arbiter.sv
// Directed bench for ql_ram_arbiter; window cycle k=0 is the sync cycle, registered outputs seen from k=1.
module tb_ql_ram_arbiter;

    localparam int unsigned AW = 24;

    logic          clk_sys = 1'b0;
    logic          RESET = 1'b1;
    logic          sync = 1'b0;
    logic          cpu_oe = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [15:0]   cpu_din = '0;
    logic [1:0]    cpu_ds = '0;
    logic [15:0]   cpu_dout;
    logic          cpu_stall;
    logic          dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [15:0]   dma_din = '0;
    logic [1:0]    dma_ds = '0;
    logic          dma_ack;
    logic [15:0]   dma_dout;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic          mem_we, mem_oe;
    logic [1:0]    mem_ds;
    logic [15:0]   mem_dout = '0;
    logic          busy;
`ifdef ARB_STATS_EN
    logic          stat_clr = 1'b0;
    logic [15:0]   stat_cpu, stat_dma, stat_forced;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // per-cycle log of the last window
    logic          l_we[8], l_oe[8], l_ack[8], l_busy[8], l_stall[8];
    logic [15:0]   l_cdout[8], l_ddout[8], l_din[8];
    logic [AW-1:0] l_addr[8];
    logic [1:0]    l_ds[8];
    logic [15:0]   rd_val;

    ql_ram_arbiter #(.SLOT_LEN(8), .RD_LAT(6), .STARVE_MAX(4), .AW(AW)) dut (
        .clk_sys(clk_sys), .RESET(RESET), .sync(sync),
        .cpu_oe(cpu_oe), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ds(cpu_ds), .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
        .dma_ds(dma_ds), .dma_ack(dma_ack), .dma_dout(dma_dout),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_oe(mem_oe),
        .mem_ds(mem_ds), .mem_dout(mem_dout), .busy(busy)
`ifdef ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_cpu(stat_cpu), .stat_dma(stat_dma), .stat_forced(stat_forced)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    // sync at k=0; mem_dout carries rd_val only at k=6, junk otherwise
    task automatic run_window(input int len, input int reset_at);
        for (int k = 0; k < len; k++) begin
            @(posedge clk_sys); #1;
            sync     = (k == 0);
            RESET    = (k == reset_at);
            mem_dout = (k == 6) ? rd_val : 16'hDEAD;
            #1;
            l_we[k] = mem_we;     l_oe[k] = mem_oe;       l_ack[k] = dma_ack;
            l_busy[k] = busy;     l_stall[k] = cpu_stall; l_cdout[k] = cpu_dout;
            l_ddout[k] = dma_dout; l_addr[k] = mem_addr;  l_din[k] = mem_din;
            l_ds[k] = mem_ds;
        end
    endtask

    function automatic int count1(input logic v[8]);
        int c = 0;
        for (int i = 0; i < 8; i++) if (v[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        n_cmp++;
        if ({mem_we, mem_oe, mem_addr, mem_din, mem_ds, cpu_dout, dma_dout, dma_ack, cpu_stall, busy}
            !== {1'b0, 1'b0, 24'h0, 16'h0, 2'b00, 16'hFFFF, 16'h0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_vals: we=%b oe=%b addr=%h din=%h ds=%b cdout=%h ddout=%h ack=%b stall=%b busy=%b",
                     mem_we, mem_oe, mem_addr, mem_din, mem_ds, cpu_dout, dma_dout, dma_ack, cpu_stall, busy);
        end
        RESET = 1'b0;
    endtask

    task automatic test_cpu_read();
        cpu_oe = 1'b1; cpu_addr = 24'h010000; rd_val = 16'h1234;
        run_window(8, -1);
        cpu_oe = 1'b0;
        n_cmp++; if (l_oe[1] !== 1'b1 || count1(l_oe) != 1) begin n_bad++;
            $display("FAIL cpu_rd_oe: oe@1=%b oe_count=%0d want 1/1", l_oe[1], count1(l_oe)); end
        n_cmp++; if (l_addr[1] !== 24'h010000) begin n_bad++;
            $display("FAIL cpu_rd_addr: got %h want 010000", l_addr[1]); end
        n_cmp++; if (l_cdout[6] !== 16'hFFFF || l_cdout[7] !== 16'h1234) begin n_bad++;
            $display("FAIL cpu_rd_data: @6=%h @7=%h want FFFF/1234", l_cdout[6], l_cdout[7]); end
        n_cmp++; if (count1(l_ack) != 0 || count1(l_we) != 0 || count1(l_busy) != 0) begin n_bad++;
            $display("FAIL cpu_rd_side: ack=%0d we=%0d busy=%0d want 0/0/0", count1(l_ack), count1(l_we), count1(l_busy)); end
        run_window(8, -1);
        n_cmp++; if (count1(l_oe) != 0 || count1(l_we) != 0 || l_cdout[7] !== 16'h1234) begin n_bad++;
            $display("FAIL idle_window: oe=%0d we=%0d cdout=%h want 0/0/1234", count1(l_oe), count1(l_we), l_cdout[7]); end
    endtask

    task automatic test_dma_write();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 24'h000100; dma_din = 16'hBEEF; dma_ds = 2'b11;
        rd_val = 16'h0000;
        run_window(8, -1);
        dma_req = 1'b0;
        n_cmp++; if (l_we[1] !== 1'b1 || count1(l_we) != 1 || count1(l_oe) != 0) begin n_bad++;
            $display("FAIL dma_wr_we: we@1=%b we=%0d oe=%0d want 1/1/0", l_we[1], count1(l_we), count1(l_oe)); end
        n_cmp++; if (l_ack[1] !== 1'b1 || count1(l_ack) != 1) begin n_bad++;
            $display("FAIL dma_wr_ack: ack@1=%b count=%0d want 1/1", l_ack[1], count1(l_ack)); end
        n_cmp++; if ({l_addr[7], l_din[7], l_ds[7]} !== {24'h000100, 16'hBEEF, 2'b11}) begin n_bad++;
            $display("FAIL dma_wr_fields: addr=%h din=%h ds=%b want 000100/BEEF/11", l_addr[7], l_din[7], l_ds[7]); end
        n_cmp++; if (l_busy[0] !== 1'b0 || count1(l_busy) != 7) begin n_bad++;
            $display("FAIL dma_wr_busy: busy@0=%b count=%0d want 0/7", l_busy[0], count1(l_busy)); end
    endtask

    task automatic test_starvation();
        cpu_oe = 1'b1; cpu_addr = 24'h020000;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 24'h000200;
        for (int w = 1; w <= 4; w++) begin
            rd_val = 16'h1000 + 16'(w);
            run_window(8, -1);
            n_cmp++; if (l_busy[1] !== 1'b0 || l_oe[1] !== 1'b1 || l_stall[1] !== 1'b0 || l_cdout[7] !== rd_val) begin n_bad++;
                $display("FAIL starve_cpu_w%0d: busy=%b oe=%b stall=%b cdout=%h want 0/1/0/%h",
                         w, l_busy[1], l_oe[1], l_stall[1], l_cdout[7], rd_val); end
        end
        rd_val = 16'h5A5A;
        run_window(8, -1);
        dma_req = 1'b0;
        n_cmp++; if (count1(l_busy) != 7 || count1(l_stall) != 7 || l_addr[1] !== 24'h000200) begin n_bad++;
            $display("FAIL forced_win: busy=%0d stall=%0d addr=%h want 7/7/000200", count1(l_busy), count1(l_stall), l_addr[1]); end
        n_cmp++; if (l_ack[6] !== 1'b1 || count1(l_ack) != 1 || l_ddout[6] !== 16'h5A5A || l_ddout[7] !== 16'h5A5A) begin n_bad++;
            $display("FAIL forced_ack: ack@6=%b count=%0d dout@6=%h dout@7=%h want 1/1/5A5A/5A5A",
                     l_ack[6], count1(l_ack), l_ddout[6], l_ddout[7]); end
        n_cmp++; if (l_cdout[7] !== 16'h1004) begin n_bad++;
            $display("FAIL forced_cpu_hold: cdout=%h want 1004", l_cdout[7]); end
        rd_val = 16'h2222;
        run_window(8, -1);
        cpu_oe = 1'b0;
        n_cmp++; if (l_busy[1] !== 1'b0 || l_stall[1] !== 1'b0 || l_oe[1] !== 1'b1 || l_addr[1] !== 24'h020000 || l_cdout[7] !== 16'h2222) begin n_bad++;
            $display("FAIL after_forced: busy=%b stall=%b oe=%b addr=%h cdout=%h want 0/0/1/020000/2222",
                     l_busy[1], l_stall[1], l_oe[1], l_addr[1], l_cdout[7]); end
    endtask

    task automatic test_early_sync();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 24'h000300; rd_val = 16'h6666;
        run_window(3, -1);
        n_cmp++; if (count1(l_ack) != 0 || l_busy[1] !== 1'b1) begin n_bad++;
            $display("FAIL early_first: ack=%0d busy=%b want 0/1", count1(l_ack), l_busy[1]); end
        run_window(8, -1);
        n_cmp++; if (count1(l_ack) != 0 || l_busy[1] !== 1'b0 || count1(l_oe) != 0) begin n_bad++;
            $display("FAIL early_gap: ack=%0d busy=%b oe=%0d want 0/0/0", count1(l_ack), l_busy[1], count1(l_oe)); end
        rd_val = 16'h7777;
        run_window(8, -1);
        dma_req = 1'b0;
        n_cmp++; if (l_ack[6] !== 1'b1 || count1(l_ack) != 1 || l_ddout[6] !== 16'h7777 || l_addr[1] !== 24'h000300) begin n_bad++;
            $display("FAIL early_retry: ack@6=%b count=%0d dout=%h addr=%h want 1/1/7777/000300",
                     l_ack[6], count1(l_ack), l_ddout[6], l_addr[1]); end
    endtask

    task automatic test_reset_midwindow();
        cpu_we = 1'b1; cpu_addr = 24'h000400; cpu_din = 16'h1111; cpu_ds = 2'b10;
        run_window(8, 2);
        cpu_we = 1'b0;
        n_cmp++; if (l_we[1] !== 1'b1 || count1(l_we) != 1) begin n_bad++;
            $display("FAIL rst_mid_we: we@1=%b count=%0d want 1/1", l_we[1], count1(l_we)); end
        n_cmp++; if ({l_oe[3], l_addr[3], l_din[3], l_ds[3], l_cdout[3], l_ddout[3], l_ack[3], l_stall[3], l_busy[3]}
                     !== {1'b0, 24'h0, 16'h0, 2'b00, 16'hFFFF, 16'h0, 1'b0, 1'b0, 1'b0}) begin n_bad++;
            $display("FAIL rst_mid_vals: oe=%b addr=%h din=%h ds=%b cdout=%h ddout=%h ack=%b stall=%b busy=%b",
                     l_oe[3], l_addr[3], l_din[3], l_ds[3], l_cdout[3], l_ddout[3], l_ack[3], l_stall[3], l_busy[3]); end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        @(posedge clk_sys); #1; stat_clr = 1'b1;
        @(posedge clk_sys); #1; stat_clr = 1'b0;
        cpu_oe = 1'b1; cpu_addr = 24'h000010; rd_val = 16'h0001;
        for (int w = 0; w < 6; w++) run_window(8, -1);
        dma_req = 1'b1; dma_we = 1'b0;
        for (int w = 0; w < 5; w++) run_window(8, -1);
        cpu_oe = 1'b0;
        for (int w = 0; w < 3; w++) run_window(8, -1);
        dma_req = 1'b0;
        n_cmp++; if ({stat_cpu, stat_dma, stat_forced} !== {16'd10, 16'd4, 16'd1}) begin n_bad++;
            $display("FAIL stats_count: cpu=%0d dma=%0d forced=%0d want 10/4/1", stat_cpu, stat_dma, stat_forced); end
        stat_clr = 1'b1;
        @(posedge clk_sys); #1; stat_clr = 1'b0;
        n_cmp++; if ({stat_cpu, stat_dma, stat_forced} !== 48'h0) begin n_bad++;
            $display("FAIL stats_clr: cpu=%0d dma=%0d forced=%0d want 0/0/0", stat_cpu, stat_dma, stat_forced); end
    endtask
`endif

    initial begin
        rd_val = 16'h0000;
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_starvation();
        test_early_sync();
        test_reset_midwindow();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ql_ram_arbiter.md
Name: ql_ram_arbiter

Overview:
Shares the single SDRAM port between the 68008 CPU path and a word-wide DMA requester, such as an MDV/QLSD block-transfer engine or a host RAM preloader. Access windows are aligned to the SDRAM controller's sync strobe (ce_p). The CPU has priority. DMA uses idle windows, and an anti-starvation counter guarantees it progress. Sits between the CPU address decode and the sdram instance.

Parameters:
SLOT_LEN, 8, clk_sys cycles per SDRAM window (sync period)
RD_LAT, 6, cycles from window start to valid mem_dout
STARVE_MAX, 4, consecutive CPU-won windows after which a pending DMA is forced
AW, 24, word address width

Ports:
clk_sys  in  1  system clock
RESET  in  1  synchronous, active-high reset
sync  in  1  one-cycle strobe marking the start of an SDRAM window
cpu_oe  in  1  CPU read request (level, sampled at sync)
cpu_we  in  1  CPU write request (level, sampled at sync)
cpu_addr  in  AW  CPU word address
cpu_din  in  16  CPU write data
cpu_ds  in  2  CPU byte enables, active-high, [1]=upper
cpu_dout  out  16  CPU read data, held until next CPU read completes
cpu_stall  out  1  high for a window in which a pending CPU access was deferred
dma_req  in  1  DMA request, held until dma_ack
dma_we  in  1  1=write, 0=read; stable while dma_req
dma_addr  in  AW  DMA word address
dma_din  in  16  DMA write data
dma_ds  in  2  DMA byte enables
dma_ack  out  1  one-cycle pulse: DMA access complete; dma_dout valid on the same cycle
dma_dout  out  16  DMA read data
mem_addr  out  AW  to sdram addr
mem_din  out  16  to sdram din
mem_we  out  1  to sdram we
mem_oe  out  1  to sdram oe
mem_ds  out  2  to sdram ds
mem_dout  in  16  from sdram dout
busy  out  1  window currently owned by DMA

Behaviour:
- States: IDLE, CPU_ACC, DMA_ACC. A decision is made only on a cycle where sync=1; otherwise the state is held.
- On sync:
  - cpu_oe|cpu_we with starve_cnt<STARVE_MAX -> CPU_ACC; starve_cnt increments if dma_req is pending, saturating at STARVE_MAX.
  - Else dma_req and no un-acked DMA transfer in flight -> DMA_ACC; starve_cnt cleared.
  - Else -> IDLE.
- Forced DMA window: dma_req pending and starve_cnt==STARVE_MAX -> DMA_ACC even if the CPU requests. cpu_stall=1 for that whole window. The CPU request must be held by the caller and is served at the next sync.
- mem_* outputs are registered and change on the cycle after sync.
  - mem_we/mem_oe are asserted for exactly that one cycle. The remaining mem_* fields hold until the next grant.
  - IDLE drives mem_we=mem_oe=0.
- Reads: at window cycle RD_LAT (counted from sync=0), mem_dout is captured into cpu_dout or dma_dout according to the owner.
- dma_ack pulses at cycle RD_LAT for reads and at cycle 1 for writes.
- The window counter runs 0..SLOT_LEN-1 and resyncs to 0 on every sync. A sync arriving before RD_LAT (early sync) aborts the capture. An aborted DMA read is retried with no ack. An aborted CPU read leaves cpu_dout unchanged.
- dma_req dropped before ack: the current window completes, no ack is issued, and the transfer is not retried.
- cpu_oe and cpu_we both high: treated as a write.
- Simultaneous CPU and DMA requests with starve_cnt<STARVE_MAX: the CPU wins.
- RESET (also mid-window):
  - state=IDLE, starve_cnt=0.
  - mem_we=mem_oe=0, mem_addr=0, mem_din=0, mem_ds=0.
  - cpu_dout=16'hFFFF, dma_dout=0, dma_ack=0, cpu_stall=0, busy=0.
  - Any in-flight access is dropped without ack.

Optional Feature:
ARB_STATS_EN:
- Defined: adds outputs stat_cpu[15:0], stat_dma[15:0] and stat_forced[15:0], plus input stat_clr. Each counter increments once per granted or forced window and wraps at 16'hFFFF->0. stat_clr or RESET zeroes all three; stat_clr wins over a same-cycle increment.
- Undefined: these ports and counters are absent, and arbitration behaviour is identical.

Test Plan:
- Only cpu_oe with addr=24'h010000 and mem_dout=16'h1234 at cycle 6 -> mem_oe pulse on cycle 1 with mem_addr=24'h010000; cpu_dout=16'h1234 from cycle 7; dma_ack never asserted.
- Only dma_req write with addr=24'h000100, din=16'hBEEF, ds=2'b11 -> mem_we on cycle 1 of the window; dma_ack pulses once at cycle 1; busy=1 for that window.
- cpu_oe held continuously, dma_req read pending -> CPU wins 4 windows, window 5 is DMA_ACC with cpu_stall=1; dma_ack at cycle 6 of window 5; CPU served again in window 6.
- Early sync arriving at cycle 3 of a DMA read window -> no dma_ack; DMA re-granted in a later idle window and acked with the correct data.
- RESET asserted at cycle 2 of a CPU write window -> next cycle all outputs equal reset values; no mem_we beyond the single already-issued pulse.
- ARB_STATS_EN defined: run 10 CPU windows, 3 DMA windows and 1 forced window, then pulse stat_clr -> stat_cpu=10, stat_dma=4, stat_forced=1 before the clear; all three read 0 after it.
